alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16, meaning operand/result width in bits (legal 8..64, power of two).
REQ-002 The block SHALL expose parameter SHW, default $clog2(WIDTH), meaning shift-amount width.
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-004 Clock  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  synchronous, active-low reset.
REQ-006 Start  input  1  request; sampled only in IDLE.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Operacioni  input  4  opcode.
REQ-010 SHAMT  input  SHW  shift amount.
REQ-011 Busy  output  1  multi-cycle operation in progress.
REQ-012 Done  output  1  one-cycle pulse; Result/flags updated this cycle.
REQ-013 Result  output  WIDTH  registered result.
REQ-014 Zero, Overflow, CarryOut  output  1 each  registered flags.

Function
REQ-015 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1000 SLL, 1001 SRL, 1010 SRA, 1011 MUL (unsigned, low WIDTH bits).
REQ-016 Unlisted opcodes SHALL complete as single-cycle ops with Result 0, Zero 1, Overflow 0, CarryOut 0.
REQ-017 FSM states SHALL be IDLE and MUL only; single-cycle ops never leave IDLE.
REQ-018 A, B, Operacioni, SHAMT SHALL be captured on the Start-accept edge; later input changes have no effect on that operation.
REQ-019 Single-cycle op accepted at edge N SHALL present Result, flags and Done=1 after edge N+1... precisely: registered at edge N, visible cycle N+1, Busy stays 0.
REQ-020 MUL accepted at edge N SHALL enter MUL, assert Busy for WIDTH cycles (shift-add, one multiplier bit per cycle), return to IDLE, and pulse Done in the cycle after Busy falls, i.e. WIDTH+1 cycles after acceptance.
REQ-021 Start while Busy=1 SHALL be ignored, not queued.
REQ-022 Start asserted in the Done cycle SHALL be accepted (back-to-back, no bubble).
REQ-023 ADD/SUB: SUB computed as A + ~B + 1; CarryOut = carry out of bit WIDTH-1; Overflow = signed two's-complement overflow.
REQ-024 MUL: Overflow SHALL be 1 iff upper WIDTH bits of the 2*WIDTH product are nonzero; CarryOut 0.
REQ-025 Logic, SLT and shift ops SHALL drive Overflow 0 and CarryOut 0; SHAMT 0 returns A unchanged; SRA replicates A[WIDTH-1].
REQ-026 Zero SHALL equal (Result == 0) for every completed op.
REQ-027 Result and flags SHALL hold their last values until the next Done.

Reset
REQ-028 Reset=0 at a rising edge SHALL force IDLE, Busy 0, Done 0, Result 0, Zero 1, Overflow 0, CarryOut 0, multiply counter 0.
REQ-029 Reset during MUL SHALL abort it with no Done pulse; Reset has priority over Start.

Configuration
REQ-030 Macro ALU_SEQ_MUL_EN defined: MUL opcode and MUL state implemented per REQ-020/024.
REQ-031 Macro ALU_SEQ_MUL_EN undefined: no multiplier hardware or MUL state; opcode 1011 treated as unlisted per REQ-016, Busy tied 0.

Verification (WIDTH=16, macro defined unless noted)
REQ-032 ADD A=0x7FFF B=0x0001 -> next cycle Result 0x8000, Overflow 1, CarryOut 0, Zero 0, Done 1.
REQ-033 SUB A=0x0005 B=0x0005 -> Result 0x0000, Zero 1, CarryOut 1, Overflow 0; SLT A=0xFFFF B=0x0001 -> Result 0x0001.
REQ-034 SRA A=0x8010 SHAMT=4 -> Result 0xF801; SLL same -> 0x0100; SRL same -> 0x0801.
REQ-035 MUL A=0x0100 B=0x0101 -> Busy 16 cycles, Done at cycle 17, Result 0x0100, Overflow 1; Start pulsed mid-Busy ignored.
REQ-036 MUL started, Reset=0 at Busy cycle 5 -> all outputs at reset values, no Done; new ADD accepted next cycle after release.
REQ-037 Macro undefined: MUL A=3 B=4 -> next cycle Result 0, Zero 1, Busy never asserted.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and opcode in, registered result and flags out.
// Start is accepted on a rising edge only while Busy is 0; Done is a one-cycle strobe qualifying Result/flags.
interface alu_seq_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       Operacioni;
    logic [SHW-1:0]   SHAMT;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Overflow;
    logic             CarryOut;
    logic             dbg_state;

    modport master (
        output Start, A, B, Operacioni, SHAMT,
        input  Busy, Done, Result, Zero, Overflow, CarryOut, dbg_state
    );

    modport slave (
        input  Start, A, B, Operacioni, SHAMT,
        output Busy, Done, Result, Zero, Overflow, CarryOut, dbg_state
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus an optional shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the MUL opcode and MUL state; otherwise opcode 1011 is unlisted.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      Clock,
    input logic      Reset,
    alu_seq_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [0:0] MUL  = 1'b1;
    localparam logic [3:0] OP_MUL = 4'b1011;
`endif
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    logic [0:0]       state;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             carry_q;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_carry;

    assign shamt = bus.SHAMT;

    // Single-cycle datapath works straight off the bus so it is registered on the accept edge.
    always_comb begin
        add_sum   = '0;
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        case (bus.Operacioni)
            OP_AND: alu_res = bus.A & bus.B;
            OP_OR:  alu_res = bus.A | bus.B;
            OP_ADD: begin
                add_sum   = {1'b0, bus.A} + {1'b0, bus.B};
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
                alu_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                add_sum   = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
                alu_ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLL: alu_res = bus.A << shamt;
            OP_SRL: alu_res = bus.A >> shamt;
            OP_SRA: alu_res = $signed(bus.A) >>> shamt;
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [SHW-1:0]     cnt;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_next;

    // prod holds {partial high, remaining multiplier bits}; each step adds and shifts right by one.
    always_comb begin
        step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
        prod_next = {step_sum, prod[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            carry_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand    <= '0;
            prod     <= '0;
            cnt      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
`ifdef ALU_SEQ_MUL_EN
                        if (bus.Operacioni == OP_MUL) begin
                            state <= MUL;
                            mcand <= bus.A;
                            prod  <= {{WIDTH{1'b0}}, bus.B};
                            cnt   <= '0;
                        end else
`endif
                        begin
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            ovf_q    <= alu_ovf;
                            carry_q  <= alu_carry;
                            done_q   <= 1'b1;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt + 1'b1;
                    // Last multiplier bit: the counter wraps back to 0 on its own.
                    if (cnt == SHW'(WIDTH-1)) begin
                        state    <= IDLE;
                        done_q   <= 1'b1;
                        result_q <= prod_next[WIDTH-1:0];
                        zero_q   <= (prod_next[WIDTH-1:0] == '0);
                        ovf_q    <= |prod_next[2*WIDTH-1:WIDTH];
                        carry_q  <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_MUL_EN
    assign bus.Busy = (state == MUL);
`else
    assign bus.Busy = 1'b0;
`endif
    assign bus.Done      = done_q;
    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = ovf_q;
    assign bus.CarryOut  = carry_q;
    assign bus.dbg_state = state;
endmodule
